// File: rtl/shift_left_2.sv
// Constant left shift with optional output register, valid flag and the
// bits shifted out of the top exposed on carry_out.
module shift_left_2 #(
    parameter int WIDTH      = 32,
    parameter int SHAMT      = 2,
    parameter bit REGISTERED = 1'b1,
    localparam int CW        = (SHAMT == 0) ? 1 : SHAMT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [CW-1:0]    carry_out,
    output logic             valid
);

    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    shifted_out;

    always_comb begin
        shifted = A << SHAMT;
    end

    generate
        if (SHAMT < 0 || SHAMT >= WIDTH) begin : g_bad_shamt
            $error("shift_left_2: SHAMT must lie in 0..WIDTH-1");
        end else if (SHAMT == 0) begin : g_no_shift_out
            assign shifted_out = '0;
        end else begin : g_shift_out
            assign shifted_out = A[WIDTH-1 -: CW];
        end
    endgenerate

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] b_q, b_d;
            logic [CW-1:0]    carry_q, carry_d;
            logic             valid_q, valid_d;

            always_comb begin
                b_d     = b_q;
                carry_d = carry_q;
                valid_d = valid_q;
                if (en) begin
                    b_d     = shifted;
                    carry_d = shifted_out;
                    valid_d = 1'b1;
                end
            end

            // Reset takes priority over a simultaneous capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q     <= '0;
                    carry_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    b_q     <= b_d;
                    carry_q <= carry_d;
                    valid_q <= valid_d;
                end
            end

            assign B         = b_q;
            assign carry_out = carry_q;
            assign valid     = valid_q;
        end else begin : g_comb
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, en};

            assign B         = shifted;
            assign carry_out = shifted_out;
            assign valid     = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_shift_left_2.sv
// Bench for shift_left_2: registered and combinational builds at SHAMT=2 and
// SHAMT=0, directed vector table plus random stimulus against an arithmetic model.
module tb_shift_left_2;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] a;

    logic [31:0] b_r, b_c, b_z, b_cz;
    logic [1:0]  c_r, c_c;
    logic [0:0]  c_z, c_cz;
    logic        v_r, v_c, v_z, v_cz;

    int tests = 0;
    int fails = 0;

    // Registered-output model state: index 0 -> SHAMT=2, index 1 -> SHAMT=0
    logic [31:0] exp_b [2];
    logic [1:0]  exp_c [2];
    logic        exp_v [2];
    int          shifts [2] = '{2, 0};

    shift_left_2 #(.WIDTH(32), .SHAMT(2), .REGISTERED(1'b1)) dut_r (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b_r), .carry_out(c_r), .valid(v_r));
    shift_left_2 #(.WIDTH(32), .SHAMT(2), .REGISTERED(1'b0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b_c), .carry_out(c_c), .valid(v_c));
    shift_left_2 #(.WIDTH(32), .SHAMT(0), .REGISTERED(1'b1)) dut_z (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b_z), .carry_out(c_z), .valid(v_z));
    shift_left_2 #(.WIDTH(32), .SHAMT(0), .REGISTERED(1'b0)) dut_cz (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b_cz), .carry_out(c_cz), .valid(v_cz));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Shift as multiplication by 2**sh modulo 2**32
    function automatic logic [63:0] ref_b(input logic [31:0] av, input int sh);
        longint unsigned x = 64'(av);
        longint unsigned m = 1;
        for (int i = 0; i < sh; i++) m = m * 2;
        return (x * m) % 64'h1_0000_0000;
    endfunction

    // Bits lost off the top: integer quotient by 2**(32-sh)
    function automatic logic [63:0] ref_c(input logic [31:0] av, input int sh);
        longint unsigned x = 64'(av);
        longint unsigned d = 1;
        for (int i = 0; i < 32 - sh; i++) d = d * 2;
        return x / d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_comb();
        check("comb_B",      64'(b_c),  ref_b(a, 2));
        check("comb_carry",  64'(c_c),  ref_c(a, 2));
        check("comb_valid",  64'(v_c),  64'd1);
        check("comb0_B",     64'(b_cz), ref_b(a, 0));
        check("comb0_carry", 64'(c_cz), 64'd0);
        check("comb0_valid", 64'(v_cz), 64'd1);
    endtask

    task automatic check_reg();
        check("reg_B",      64'(b_r), 64'(exp_b[0]));
        check("reg_carry",  64'(c_r), 64'(exp_c[0]));
        check("reg_valid",  64'(v_r), 64'(exp_v[0]));
        check("reg0_B",     64'(b_z), 64'(exp_b[1]));
        check("reg0_carry", 64'(c_z), 64'(exp_c[1]));
        check("reg0_valid", 64'(v_z), 64'(exp_v[1]));
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [31:0] av);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                exp_b[k] = '0;
                exp_c[k] = '0;
                exp_v[k] = 1'b0;
            end else if (e) begin
                exp_b[k] = 32'(ref_b(av, shifts[k]));
                exp_c[k] = 2'(ref_c(av, shifts[k]));
                exp_v[k] = 1'b1;
            end
        end
    endtask

    // Drive inputs at negedge, check combinational builds, clock, sample 1ns later
    task automatic drive(input logic r, input logic e, input logic [31:0] av);
        @(negedge clk);
        rst = r;
        en  = e;
        a   = av;
        #1;
        check_comb();
        @(posedge clk);
        model_edge(r, e, av);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
        logic        v;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        for (int k = 0; k < 2; k++) begin
            exp_b[k] = '0;
            exp_c[k] = '0;
            exp_v[k] = 1'b0;
        end

        vecs[0]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 2'b11, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h00000001, 32'h00000004, 2'b00, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h40000000, 32'h00000000, 2'b01, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h12345678, 32'h48D159E0, 2'b00, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'hAAAAAAAA, 32'h48D159E0, 2'b00, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'hAAAAAAAA, 32'h48D159E0, 2'b00, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'hAAAAAAAA, 32'h48D159E0, 2'b00, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h80000003, 32'h0000000C, 2'b10, 1'b1};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].a);
            check($sformatf("tbl%0d_B", i),     64'(b_r), 64'(vecs[i].b));
            check($sformatf("tbl%0d_carry", i), 64'(c_r), 64'(vecs[i].c));
            check($sformatf("tbl%0d_valid", i), 64'(v_r), 64'(vecs[i].v));
            check_reg();
        end

        // Combinational build responds without any clock edge
        @(negedge clk);
        a = 32'hFFFFFFFF;
        #1;
        check("seq_comb_B_ff",     64'(b_c), 64'hFFFFFFFC);
        check("seq_comb_carry_ff", 64'(c_c), 64'd3);
        a = 32'h80000003;
        #1;
        check("seq_comb_B_80",     64'(b_c), 64'h0000000C);
        check("seq_comb_carry_80", 64'(c_c), 64'd2);
        check("seq_comb_valid",    64'(v_c), 64'd1);
        a = 32'hDEADBEEF;
        #1;
        check("seq_comb0_B",       64'(b_cz), 64'hDEADBEEF);
        check("seq_comb0_carry",   64'(c_cz), 64'd0);

        // A change just before the edge must not disturb the held output
        drive(1'b0, 1'b1, 32'hDEADBEEF);
        check("seq_reg0_B",     64'(b_z), 64'hDEADBEEF);
        check("seq_reg0_carry", 64'(c_z), 64'd0);
        check("seq_reg_B_de",   64'(b_r), 64'h7AB6FBBC);
        check("seq_reg_c_de",   64'(c_r), 64'd3);
        @(negedge clk);
        en = 1'b1;
        a  = 32'h00000001;
        #2;
        check("seq_latency_B",  64'(b_r), 64'h7AB6FBBC);
        @(posedge clk);
        model_edge(1'b0, 1'b1, 32'h00000001);
        #1;
        check("seq_after_edge_B", 64'(b_r), 64'h00000004);
        check_reg();

        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        e;
            logic [31:0] av;
            r  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            av = $urandom;
            drive(r, e, av);
            check_reg();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
